hpf_mc: RTL and testbench

- Multi-channel, time-multiplexed first-order IIR high-pass filter. Successor to the single-channel fixed-coefficient HPF in the pre-processing chain.
- Implements y[n] = sat(round(alpha·(y[n-1] + x[n] − x[n-1]))) per channel, with a runtime-programmable coefficient, a bypass mode and a state flush.
- Sits between the ADC sample demux and the downstream LPF/feature blocks.
- Uses a valid/ready stream on both sides, and processes one sample at a time through a 3-stage FSM.

---
 rtl/hpf_mc.sv | 121 ++++++++++++
 tb/tb_hpf_mc.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/hpf_mc.sv
// hpf_mc: time-multiplexed multi-channel first-order IIR high-pass filter with
// programmable coefficient, bypass and history flush.
module hpf_mc #(
  parameter int WIDTH    = 10,
  parameter int SCALE    = 15,
  parameter int CHANNELS = 4,
  parameter int CHW      = 2
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [CHW-1:0]          in_ch,
  input  logic signed [WIDTH-1:0] x_in,
  input  logic [SCALE+1:0]        alpha_q,
  input  logic                    bypass,
  input  logic                    flush,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [CHW-1:0]          out_ch,
  output logic signed [WIDTH-1:0] y_out
);
  localparam int PW = WIDTH + SCALE + 4;
  localparam logic signed [PW:0] HALF = (PW+1)'(1) << (SCALE-1);
  localparam logic signed [PW:0] MAXV = (PW+1)'((1 << (WIDTH-1)) - 1);
  localparam logic signed [PW:0] MINV = -MAXV - 1;
  typedef enum logic [1:0] {IDLE, SUM, MUL, OUT} state_t;
  state_t state_q, state_d;
  logic rdy_q;
  logic signed [WIDTH-1:0] x_q, x_d, y_q, y_d, y_sat;
  logic [CHW-1:0] ch_q, ch_d, out_ch_q, out_ch_d;
  logic [SCALE+1:0] coef_q, coef_d;
  logic byp_q, byp_d, out_valid_q, out_valid_d;
  logic signed [WIDTH+1:0] s_q, s_d;
  logic signed [PW:0] p, r;
  logic signed [WIDTH-1:0] x_prev_q [CHANNELS];
  logic signed [WIDTH-1:0] x_prev_d [CHANNELS];
  logic signed [WIDTH-1:0] y_prev_q [CHANNELS];
  logic signed [WIDTH-1:0] y_prev_d [CHANNELS];
  assign in_ready  = rdy_q && state_q == IDLE;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign y_out     = y_q;
  // coefficient is zero-extended so the product treats it as non-negative
  assign p = s_q * $signed({1'b0, coef_q});
  assign r = (p + HALF) >>> SCALE;
  assign y_sat = r > MAXV ? MAXV[WIDTH-1:0] : r < MINV ? MINV[WIDTH-1:0] : r[WIDTH-1:0];
  always_comb begin
    state_d     = state_q;
    x_d         = x_q;
    ch_d        = ch_q;
    coef_d      = coef_q;
    byp_d       = byp_q;
    s_d         = s_q;
    y_d         = y_q;
    out_ch_d    = out_ch_q;
    out_valid_d = out_valid_q;
    x_prev_d    = x_prev_q;
    y_prev_d    = y_prev_q;
    case (state_q)
      IDLE: begin
        if (flush) begin
          x_prev_d = '{default: '0};
          y_prev_d = '{default: '0};
        end
        if (in_valid && rdy_q) begin
          x_d     = x_in;
          ch_d    = in_ch;
          coef_d  = alpha_q;
          byp_d   = bypass;
          state_d = int'(in_ch) < CHANNELS ? SUM : IDLE;
        end
      end
      SUM: begin
        s_d     = (WIDTH+2)'(y_prev_q[ch_q]) + (WIDTH+2)'(x_q) - (WIDTH+2)'(x_prev_q[ch_q]);
        state_d = MUL;
      end
      MUL: begin
        y_d            = byp_q ? x_q : y_sat;
        out_ch_d       = ch_q;
        out_valid_d    = 1'b1;
        y_prev_d[ch_q] = y_d;
        x_prev_d[ch_q] = x_q;
        state_d        = OUT;
      end
      default: begin
        out_valid_d = out_ready ? 1'b0 : out_valid_q;
        state_d     = out_ready ? IDLE : OUT;
      end
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rdy_q       <= 1'b0;
      x_q         <= '0;
      ch_q        <= '0;
      coef_q      <= '0;
      byp_q       <= 1'b0;
      s_q         <= '0;
      y_q         <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      x_prev_q    <= '{default: '0};
      y_prev_q    <= '{default: '0};
    end else begin
      state_q     <= state_d;
      rdy_q       <= 1'b1;
      x_q         <= x_d;
      ch_q        <= ch_d;
      coef_q      <= coef_d;
      byp_q       <= byp_d;
      s_q         <= s_d;
      y_q         <= y_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      x_prev_q    <= x_prev_d;
      y_prev_q    <= y_prev_d;
    end
  end
endmodule

// File: tb/tb_hpf_mc.sv
// tb_hpf_mc: directed self-checking bench for hpf_mc with hand-computed results.
module tb_hpf_mc;
  localparam int W = 10, S = 15, C = 4, CW = 2;
  logic clk = 0, rst_n = 0, in_valid = 0, bypass = 0, flush = 0, out_ready = 1;
  logic in_ready, out_valid;
  logic [CW-1:0] in_ch = '0, out_ch;
  logic signed [W-1:0] x_in = '0, y_out;
  logic [S+1:0] alpha_q = '0;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  hpf_mc #(.WIDTH(W), .SCALE(S), .CHANNELS(C), .CHW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_ch(in_ch), .x_in(x_in), .alpha_q(alpha_q), .bypass(bypass),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .out_ch(out_ch), .y_out(y_out)
  );
  // Handshake one sample, scramble alpha/bypass afterwards, wait for out_valid.
  task automatic send(input int ch, input int x, input int a, input bit byp, input bit fl,
                      output int y, output int oc, output int lat);
    int n = 0;
    @(negedge clk);
    while (!in_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    in_valid = 1; in_ch = CW'(ch); x_in = W'(x); alpha_q = (S+2)'(a); bypass = byp; flush = fl;
    @(negedge clk);
    in_valid = 0; alpha_q = '0; bypass = ~byp; flush = 0; lat = 1;
    while (!out_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    y = int'(y_out); oc = int'(out_ch);
    if (!out_valid) lat = -1;
    bypass = 0;
  endtask
  task automatic do_flush();
    @(negedge clk);
    flush = 1;
    @(negedge clk);
    flush = 0;
  endtask
  task automatic test_reset();
    rst_n = 0;
    repeat (3) @(negedge clk);
    checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++; if (y_out !== '0) begin failures++; $display("FAIL reset_y_out got=%0d exp=0", y_out); end
    checks++; if (out_ch !== '0) begin failures++; $display("FAIL reset_out_ch got=%0d exp=0", out_ch); end
    rst_n = 1;
    @(negedge clk);
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
  endtask
  task automatic test_basic();
    int y, oc, lat;
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94) begin failures++; $display("FAIL basic1_y got=%0d exp=94", y); end
    checks++; if (oc != 0) begin failures++; $display("FAIL basic1_ch got=%0d exp=0", oc); end
    checks++; if (lat != 3) begin failures++; $display("FAIL basic1_latency got=%0d exp=3", lat); end
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 88) begin failures++; $display("FAIL basic2_y got=%0d exp=88", y); end
    checks++; if (oc != 0) begin failures++; $display("FAIL basic2_ch got=%0d exp=0", oc); end
  endtask
  task automatic test_interleave();
    int y, oc, lat;
    do_flush();
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94 || oc != 0) begin failures++; $display("FAIL inter1 got=%0d/ch%0d exp=94/ch0", y, oc); end
    send(1, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94 || oc != 1) begin failures++; $display("FAIL inter2 got=%0d/ch%0d exp=94/ch1", y, oc); end
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 88 || oc != 0) begin failures++; $display("FAIL inter3 got=%0d/ch%0d exp=88/ch0", y, oc); end
  endtask
  task automatic test_saturation();
    int y, oc, lat;
    do_flush();
    send(2, 300, 65536, 0, 0, y, oc, lat);
    checks++; if (y != 511) begin failures++; $display("FAIL sat_pos1 got=%0d exp=511", y); end
    send(2, 300, 65536, 0, 0, y, oc, lat);
    checks++; if (y != 511) begin failures++; $display("FAIL sat_pos2 got=%0d exp=511", y); end
    send(2, 0, 32768, 0, 0, y, oc, lat);
    checks++; if (y != 211) begin failures++; $display("FAIL sat_history got=%0d exp=211", y); end
    send(3, -300, 65536, 0, 0, y, oc, lat);
    checks++; if (y != -512 || oc != 3) begin failures++; $display("FAIL sat_neg got=%0d/ch%0d exp=-512/ch3", y, oc); end
  endtask
  task automatic test_rounding();
    int y, oc, lat;
    do_flush();
    send(0, -512, 30831, 0, 0, y, oc, lat);
    checks++; if (y != -482) begin failures++; $display("FAIL round_neg got=%0d exp=-482", y); end
    send(1, 5, 0, 0, 0, y, oc, lat);
    checks++; if (y != 0) begin failures++; $display("FAIL alpha_zero got=%0d exp=0", y); end
  endtask
  task automatic test_backpressure();
    int y, oc, lat;
    do_flush();
    out_ready = 0;
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94 || lat != 3) begin failures++; $display("FAIL bp_first got=%0d lat=%0d exp=94 lat=3", y, lat); end
    in_valid = 1; in_ch = 0; x_in = 500; alpha_q = 30831;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++; if (y_out !== 10'sd94 || out_ch !== 2'd0 || out_valid !== 1'b1) begin
        failures++; $display("FAIL bp_hold%0d got=%0d/ch%0d/v%b exp=94/ch0/v1", i, y_out, out_ch, out_valid);
      end
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_in_ready%0d got=%b exp=0", i, in_ready); end
    end
    in_valid = 0; out_ready = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      failures++; $display("FAIL bp_release got=v%b/r%b exp=v0/r1", out_valid, in_ready);
    end
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 88) begin failures++; $display("FAIL bp_no_accept got=%0d exp=88", y); end
  endtask
  task automatic test_bypass();
    int y, oc, lat;
    do_flush();
    send(1, -7, 30831, 1, 0, y, oc, lat);
    checks++; if (y != -7 || oc != 1) begin failures++; $display("FAIL bypass1 got=%0d/ch%0d exp=-7/ch1", y, oc); end
    send(1, -7, 32768, 0, 0, y, oc, lat);
    checks++; if (y != -7) begin failures++; $display("FAIL bypass_then_filter got=%0d exp=-7", y); end
    send(2, 300, 0, 1, 0, y, oc, lat);
    checks++; if (y != 300) begin failures++; $display("FAIL bypass_alpha0 got=%0d exp=300", y); end
  endtask
  task automatic test_flush();
    int y, oc, lat;
    send(0, 50, 30831, 0, 0, y, oc, lat);
    do_flush();
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94) begin failures++; $display("FAIL flush_idle got=%0d exp=94", y); end
    send(0, 100, 30831, 0, 1, y, oc, lat);
    checks++; if (y != 94) begin failures++; $display("FAIL flush_with_sample got=%0d exp=94", y); end
  endtask
  task automatic test_reset_mid();
    int y, oc, lat;
    send(0, 100, 30831, 0, 0, y, oc, lat);
    @(negedge clk);
    in_valid = 1; in_ch = 0; x_in = 100; alpha_q = 30831;
    @(negedge clk);
    in_valid = 0;
    @(negedge clk);
    rst_n = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid%0d got=%b exp=0", i, out_valid); end
    end
    rst_n = 1;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_after got=%b exp=0", out_valid); end
    send(0, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94) begin failures++; $display("FAIL midrst_ch0 got=%0d exp=94", y); end
    send(2, 100, 30831, 0, 0, y, oc, lat);
    checks++; if (y != 94) begin failures++; $display("FAIL midrst_ch2 got=%0d exp=94", y); end
  endtask
  initial begin
    test_reset();
    test_basic();
    test_interleave();
    test_saturation();
    test_rounding();
    test_backpressure();
    test_bypass();
    test_flush();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
